// File: rtl/bubsys_video_timing_gen.sv
// GX400 / Bubble System raster timing: 9-bit H/V counters with
// registered blanking, sync, vblank IRQ strobe and frame parity.
module bubsys_video_timing_gen #(
  parameter logic [8:0] H_START     = 9'd128,
  parameter logic [8:0] V_START     = 9'd248,
  parameter logic [8:0] HVIS_START  = 9'd278,
  parameter logic [8:0] HVIS_END    = 9'd149,
  parameter logic [8:0] VVIS_START  = 9'd272,
  parameter logic [8:0] VVIS_END    = 9'd495,
  parameter logic [8:0] HSYNC_START = 9'd176,
  parameter logic [8:0] HSYNC_END   = 9'd207,
  parameter logic [8:0] VSYNC_START = 9'd500,
  parameter logic [8:0] VSYNC_END   = 9'd507
) (
  input  logic       i_EMU_MCLK,
  input  logic       i_EMU_INITRST_n,
  input  logic       i_EMU_CLK6MPCEN_n,
  output logic [8:0] o_HCOUNTER,
  output logic [8:0] o_VCOUNTER,
  output logic       o_HBLANK_n,
  output logic       o_VBLANK_n,
  output logic       o_DE,
  output logic       o_HSYNC_n,
  output logic       o_VSYNC_n,
  output logic       o_VBLANK_IRQ_n,
  output logic       o_FRAME_PARITY
);

  localparam logic [8:0] IRQ_LINE = VVIS_END + 9'd1;

  logic [8:0] r_h;
  logic [8:0] r_v;
  logic       r_hblank_n;
  logic       r_vblank_n;
  logic       r_de;
  logic       r_hsync_n;
  logic       r_vsync_n;
  logic       r_irq_n;
  logic       r_parity;

  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [8:0] w_h_nxt;
  logic [8:0] w_v_nxt;
  logic       w_hvis;
  logic       w_vvis;
  logic       w_hsync;
  logic       w_vsync;
  logic       w_irq;

  assign w_h_wrap = (r_h == 9'd511);
  assign w_v_wrap = (r_v == 9'd511);
  assign w_h_nxt  = w_h_wrap ? H_START : r_h + 9'd1;
  assign w_v_nxt  = !w_h_wrap ? r_v :
                    w_v_wrap  ? V_START : r_v + 9'd1;

  // Decode the next counts so decodes line up with the counters.
  // The visible H window straddles the wrap, hence the OR.
  assign w_hvis  = (w_h_nxt >= HVIS_START) || (w_h_nxt <= HVIS_END);
  assign w_vvis  = (w_v_nxt >= VVIS_START) && (w_v_nxt <= VVIS_END);
  assign w_hsync = (w_h_nxt >= HSYNC_START) && (w_h_nxt <= HSYNC_END);
  assign w_vsync = (w_v_nxt >= VSYNC_START) && (w_v_nxt <= VSYNC_END);
  assign w_irq   = (w_v_nxt == IRQ_LINE) && (w_h_nxt == H_START);

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      r_h        <= H_START;
      r_v        <= V_START;
      r_hblank_n <= 1'b0;
      r_vblank_n <= 1'b0;
      r_de       <= 1'b0;
      r_hsync_n  <= 1'b1;
      r_vsync_n  <= 1'b1;
      r_irq_n    <= 1'b1;
      r_parity   <= 1'b0;
    end else if (!i_EMU_CLK6MPCEN_n) begin
      r_h        <= w_h_nxt;
      r_v        <= w_v_nxt;
      r_hblank_n <= w_hvis;
      r_vblank_n <= w_vvis;
      r_de       <= w_hvis & w_vvis;
      r_hsync_n  <= ~w_hsync;
      r_vsync_n  <= ~w_vsync;
      r_irq_n    <= ~w_irq;
      r_parity   <= r_parity ^ w_irq;
    end
  end

  assign o_HCOUNTER     = r_h;
  assign o_VCOUNTER     = r_v;
  assign o_HBLANK_n     = r_hblank_n;
  assign o_VBLANK_n     = r_vblank_n;
  assign o_DE           = r_de;
  assign o_HSYNC_n      = r_hsync_n;
  assign o_VSYNC_n      = r_vsync_n;
  assign o_VBLANK_IRQ_n = r_irq_n;
  assign o_FRAME_PARITY = r_parity;

endmodule

// File: tb/tb_bubsys_video_timing_gen.sv
// Directed bench: a default-timing instance for line behaviour and a
// short-frame instance (V_START=480) for frame, wrap and IRQ behaviour.
module tb_bubsys_video_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic cen_n;

  always #5 clk = ~clk;

  logic [8:0] h, v;
  logic       hb, vb, de, hs, vs, irq, par;
  logic [8:0] s_h, s_v;
  logic       s_hb, s_vb, s_de, s_hs, s_vs, s_irq, s_par;

  bubsys_video_timing_gen dut (
    .i_EMU_MCLK        (clk),
    .i_EMU_INITRST_n   (rst_n),
    .i_EMU_CLK6MPCEN_n (cen_n),
    .o_HCOUNTER        (h),
    .o_VCOUNTER        (v),
    .o_HBLANK_n        (hb),
    .o_VBLANK_n        (vb),
    .o_DE              (de),
    .o_HSYNC_n         (hs),
    .o_VSYNC_n         (vs),
    .o_VBLANK_IRQ_n    (irq),
    .o_FRAME_PARITY    (par)
  );

  // 32 lines/frame: visible lines 480..495, IRQ at 496, VSYNC 500..507
  bubsys_video_timing_gen #(.V_START(9'd480)) dut_s (
    .i_EMU_MCLK        (clk),
    .i_EMU_INITRST_n   (rst_n),
    .i_EMU_CLK6MPCEN_n (cen_n),
    .o_HCOUNTER        (s_h),
    .o_VCOUNTER        (s_v),
    .o_HBLANK_n        (s_hb),
    .o_VBLANK_n        (s_vb),
    .o_DE              (s_de),
    .o_HSYNC_n         (s_hs),
    .o_VSYNC_n         (s_vs),
    .o_VBLANK_IRQ_n    (s_irq),
    .o_FRAME_PARITY    (s_par)
  );

  int ncmp = 0;
  int nerr = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int hb_cnt, hs_cnt, hs_first, rise_h, fall_h;
    logic prev;
    int nirq, de_cnt, vs_cnt, vs_err, irq_bad;
    logic par1, par2;
    bit found;
    int early;

    rst_n = 1'b0;
    cen_n = 1'b0;
    step(3);
    check("rst_h", h, 128);
    check("rst_v", v, 248);
    check("rst_hb", hb, 0);
    check("rst_vb", vb, 0);
    check("rst_de", de, 0);
    check("rst_hs", hs, 1);
    check("rst_vs", vs, 1);
    check("rst_irq", irq, 1);
    check("rst_par", par, 0);

    rst_n = 1'b1;
    #1;
    check("rel_h", h, 128);
    step(1);
    check("first_h", h, 129);
    check("first_hb", hb, 1);

    // One full line: every H value 130..511,128,129 seen once
    hb_cnt = 0; hs_cnt = 0; hs_first = -1;
    rise_h = -1; fall_h = -1; prev = hb;
    for (int i = 0; i < 384; i++) begin
      step(1);
      if (hb && !prev) rise_h = h;
      if (!hb && prev) fall_h = h;
      if (hb) hb_cnt++;
      if (!hs) begin
        if (hs_first < 0) hs_first = h;
        hs_cnt++;
      end
      prev = hb;
    end
    check("line_h", h, 129);
    check("line_v", v, 249);
    check("hb_rise", rise_h, 278);
    check("hb_fall", fall_h, 150);
    check("hb_cnt", hb_cnt, 256);
    check("hs_cnt", hs_cnt, 32);
    check("hs_first", hs_first, 176);

    step(171);
    check("pre_stall_h", h, 300);
    cen_n = 1'b1;
    step(50);
    check("stall_h", h, 300);
    check("stall_v", v, 249);
    check("stall_hb", hb, 1);
    cen_n = 1'b0;
    step(1);
    check("resume_h", h, 301);

    // Two IRQs on the short-frame instance, one frame apart
    nirq = 0; de_cnt = 0; vs_cnt = 0; vs_err = 0; irq_bad = 0;
    par1 = 1'b0; par2 = 1'b1;
    for (int i = 0; i < 30000 && nirq < 2; i++) begin
      step(1);
      if (nirq == 1) begin
        de_cnt += int'(s_de);
        if (!s_vs) vs_cnt++;
        if (s_vs !== !(s_v >= 500 && s_v <= 507)) vs_err++;
      end
      if (!s_irq) begin
        nirq++;
        if (s_v != 9'd496 || s_h != 9'd128) irq_bad++;
        if (nirq == 1) par1 = s_par;
        else par2 = s_par;
      end
    end
    check("irq_count", nirq, 2);
    check("irq_pos", irq_bad, 0);
    check("par_1", par1, 1);
    check("par_2", par2, 0);
    check("de_frame", de_cnt, 4096);
    check("vs_cnt", vs_cnt, 3072);
    check("vs_model", vs_err, 0);

    cen_n = 1'b1;
    step(20);
    check("irq_stall", s_irq, 0);
    check("irq_stall_h", s_h, 128);
    cen_n = 1'b0;
    step(1);
    check("irq_end", s_irq, 1);
    check("irq_end_h", s_h, 129);

    found = 1'b0;
    for (int i = 0; i < 13000; i++) begin
      if (s_h == 9'd511 && s_v == 9'd511) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
    check("wrap_found", found, 1);
    step(1);
    check("wrap_h", s_h, 128);
    check("wrap_v", s_v, 480);
    check("wrap_vs", s_vs, 1);

    found = 1'b0;
    for (int i = 0; i < 13000; i++) begin
      step(1);
      if (!s_irq) begin
        found = 1'b1;
        break;
      end
    end
    check("irq3_found", found, 1);
    check("irq3_v", s_v, 496);
    check("irq3_h", s_h, 128);

    rst_n = 1'b0;
    #1;
    check("arst_irq", s_irq, 1);
    check("arst_h", s_h, 128);
    check("arst_v", s_v, 480);
    check("arst_par", s_par, 0);
    check("arst_dv", v, 248);
    step(3);
    rst_n = 1'b1;

    found = 1'b0;
    early = 0;
    for (int i = 0; i < 7000; i++) begin
      step(1);
      if (s_v == 9'd496 && s_h == 9'd128) begin
        found = 1'b1;
        break;
      end
      if (!s_irq) early++;
    end
    check("post_found", found, 1);
    check("post_early", early, 0);
    check("post_irq", s_irq, 0);
    check("post_par", s_par, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
